// File: rtl/ppi_bus_master.sv
// ppi_bus_master: host request/response front end driving an 8255-style
// parallel peripheral bus with programmable setup/strobe/hold timing.
module ppi_bus_master #(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic       Clk,
  input  logic       nReset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_wr,
  input  logic [1:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       nCs,
  output logic       nRe,
  output logic       nWr,
  output logic [1:0] A,
  inout  wire  [7:0] D
);

  localparam int unsigned CntW  = 4;
  localparam int unsigned AddrW = 2;
  localparam int unsigned DataW = 8;

  // Terminal count of each phase; the counter runs 0..LEN-1 inside a phase.
  localparam logic [CntW-1:0] SetupLast  = CntW'(SETUP_CYC - 1);
  localparam logic [CntW-1:0] StrobeLast = CntW'(STROBE_CYC - 1);
  localparam logic [CntW-1:0] HoldLast   = CntW'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } busStateT;

  typedef struct packed {
    logic             wr;
    logic [AddrW-1:0] addr;
    logic [DataW-1:0] wdata;
  } reqT;

  busStateT          state;
  busStateT          stateNext;
  logic [CntW-1:0]   phaseCnt;
  logic [CntW-1:0]   phaseCntNext;
  reqT               reqLat;
  reqT               reqLatNext;
  logic [DataW-1:0]  rdCap;
  logic [DataW-1:0]  rdCapNext;
  logic              dOe;
  logic              dOeNext;
  logic [DataW-1:0]  dOut;
  logic [DataW-1:0]  dOutNext;
  logic              nCsNext;
  logic              nReNext;
  logic              nWrNext;
  logic [AddrW-1:0]  aNext;
  logic              reqReadyNext;
  logic              rspValidNext;
  logic [DataW-1:0]  rspRdataNext;
  logic              busy;

  // Data bus driven only from registered enable/data, so no glitches escape.
  assign D = dOe ? dOut : {DataW{1'bz}};

  // Next-state, phase counter and next value of every registered output.
  always_comb begin
    stateNext    = state;
    phaseCntNext = phaseCnt + CntW'(1);
    reqLatNext   = reqLat;
    rdCapNext    = rdCap;

    case (state)
      IDLE: begin
        phaseCntNext = '0;
        if (req_valid && req_ready) begin
          reqLatNext.wr    = req_wr;
          reqLatNext.addr  = req_addr;
          reqLatNext.wdata = req_wdata;
          stateNext        = SETUP;
        end
      end
      SETUP: begin
        if (phaseCnt == SetupLast) begin
          stateNext    = STROBE;
          phaseCntNext = '0;
        end
      end
      STROBE: begin
        if (phaseCnt == StrobeLast) begin
          stateNext    = HOLD;
          phaseCntNext = '0;
          // Read data is taken while nRe is still low on this edge.
          rdCapNext    = reqLat.wr ? '0 : D;
        end
      end
      HOLD: begin
        if (phaseCnt == HoldLast) begin
          stateNext    = IDLE;
          phaseCntNext = '0;
        end
      end
      default: begin
        stateNext    = IDLE;
        phaseCntNext = '0;
      end
    endcase

    // Bus outputs follow the state being entered, so they change on the same
    // edge as the state register.
    busy         = (stateNext != IDLE);
    nCsNext      = !busy;
    nReNext      = !((stateNext == STROBE) && !reqLatNext.wr);
    nWrNext      = !((stateNext == STROBE) && reqLatNext.wr);
    aNext        = busy ? reqLatNext.addr : A;
    dOeNext      = busy && reqLatNext.wr;
    dOutNext     = reqLatNext.wdata;
    reqReadyNext = !busy;
    rspValidNext = (state == HOLD) && (stateNext == IDLE);
    rspRdataNext = rspValidNext ? rdCap : rsp_rdata;
  end

  // State, counter, latched request and registered outputs.
  always_ff @(posedge Clk) begin
    if (!nReset) begin
      state     <= IDLE;
      phaseCnt  <= '0;
      reqLat    <= '0;
      rdCap     <= '0;
      dOe       <= 1'b0;
      dOut      <= '0;
      nCs       <= 1'b1;
      nRe       <= 1'b1;
      nWr       <= 1'b1;
      A         <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= stateNext;
      phaseCnt  <= phaseCntNext;
      reqLat    <= reqLatNext;
      rdCap     <= rdCapNext;
      dOe       <= dOeNext;
      dOut      <= dOutNext;
      nCs       <= nCsNext;
      nRe       <= nReNext;
      nWr       <= nWrNext;
      A         <= aNext;
      req_ready <= reqReadyNext;
      rsp_valid <= rspValidNext;
      rsp_rdata <= rspRdataNext;
    end
  end

endmodule
